// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity frame link: receiver state encodings and line levels.
// The transmitter imports the same package, so the two ends agree on encodings.
package parity_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_PARITY    = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam int   CNT_W     = 5;

endpackage

// File: rtl/parity_frame_rx_xor_nand2.sv
// Two-input XOR built purely from four NAND gates, used as the serial parity accumulator cell.
module xor_nand2 (
    output logic o_y,
    input  logic i_a,
    input  logic i_b
);

    logic w_n1;
    logic w_n2;
    logic w_n3;

    assign w_n1 = ~(i_a & i_b);
    assign w_n2 = ~(i_a & w_n1);
    assign w_n3 = ~(i_b & w_n1);
    assign o_y  = ~(w_n2 & w_n3);

endmodule

// File: rtl/parity_frame_rx.sv
// Strobed serial frame receiver: start, DATA_W bits LSB-first, parity, stop.
// Presents the word with parity/framing status and a one-cycle valid pulse.
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (ODD != 0) ? 1'b1 : 1'b0;

    rx_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_acc;
    logic               r_perr;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic               r_busy;
    logic               w_acc_next;

    xor_nand2 u_acc_xor (
        .o_y (w_acc_next),
        .i_a (r_acc),
        .i_b (rx_in)
    );

    // Frame sequencing; every output is registered here and only strobes advance state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_acc        <= 1'b0;
            r_perr       <= 1'b0;
            r_shift      <= {DATA_W{1'b0}};
            r_data       <= {DATA_W{1'b0}};
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_in != LINE_IDLE) begin
                            r_acc   <= 1'b0;
                            r_cnt   <= {CNT_W{1'b0}};
                            r_busy  <= 1'b1;
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_cnt == CNT_W'(i)) begin
                                r_shift[i] <= rx_in;
                            end
                        end
                        r_acc <= w_acc_next;
                        // Counter holds at the last index so it never wraps inside a frame.
                        if (r_cnt == LAST_BIT) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_perr  <= w_acc_next ^ ODD_BIT;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_data       <= r_shift;
                        r_parity_err <= r_perr;
                        r_frame_err  <= (rx_in != LINE_IDLE);
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= (rx_in == LINE_IDLE) ? ST_IDLE : ST_WAIT_HIGH;
                    end
                    ST_WAIT_HIGH: begin
                        // A held-low line must return high before another start is seen.
                        if (rx_in == LINE_IDLE) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_HIGH;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed self-checking bench for parity_frame_rx: even-parity instance plus an odd-parity instance.
module tb_parity_frame_rx;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] o_data_out;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    int errors = 0;
    int checks = 0;
    logic seen_activity;

    parity_frame_rx #(.DATA_W(8), .ODD(0)) u_even (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    parity_frame_rx #(.DATA_W(8), .ODD(1)) u_odd (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx_in      (rx_in),
        .data_out   (o_data_out),
        .data_valid (o_data_valid),
        .parity_err (o_parity_err),
        .frame_err  (o_frame_err),
        .busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b);
        @(negedge clk);
        bit_en = 1'b1;
        rx_in  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_en = 1'b0;
            rx_in  = ~rx_in;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bit_en = 1'b0;
        rx_in  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gaps);
        strobe(1'b0);
        chk("busy_rise", 16'(busy), 16'h1);
        chk("valid_low_start", 16'(data_valid), 16'h0);
        for (int i = 0; i < 8; i++) begin
            gap(gaps);
            strobe(d[i]);
        end
        gap(gaps);
        strobe(par);
        chk("busy_parity", 16'(busy), 16'h1);
        chk("valid_low_parity", 16'(data_valid), 16'h0);
        gap(gaps);
        strobe(stp);
        chk("valid_pulse", 16'(data_valid), 16'h1);
        chk("busy_fall", 16'(busy), 16'h0);
    endtask

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        rx_in  = 1'b1;
        seen_activity = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 16'(data_out), 16'h0);
        chk("rst_valid", 16'(data_valid), 16'h0);
        chk("rst_perr", 16'(parity_err), 16'h0);
        chk("rst_ferr", 16'(frame_err), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // 0xA5: four ones, even parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        chk("a5_data", 16'(data_out), 16'h00A5);
        chk("a5_perr", 16'(parity_err), 16'h0);
        chk("a5_ferr", 16'(frame_err), 16'h0);
        // strobe stays high with an idle bit: valid must still drop
        strobe(1'b1);
        chk("a5_valid_one_cycle", 16'(data_valid), 16'h0);
        chk("a5_data_hold", 16'(data_out), 16'h00A5);

        // 0x01 with parity 0 follows with no idle bit after its stop
        send_frame(8'h01, 1'b0, 1'b1, 0);
        chk("bad_par_data", 16'(data_out), 16'h0001);
        chk("bad_par_perr", 16'(parity_err), 16'h1);
        chk("bad_par_ferr", 16'(frame_err), 16'h0);
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        chk("b2b_data", 16'(data_out), 16'h00A5);
        chk("b2b_perr", 16'(parity_err), 16'h0);

        // break: 0x7E with stop 0, then line held low
        send_frame(8'h7E, 1'b0, 1'b0, 0);
        chk("brk_data", 16'(data_out), 16'h007E);
        chk("brk_ferr", 16'(frame_err), 16'h1);
        chk("brk_perr", 16'(parity_err), 16'h0);
        for (int i = 0; i < 20; i++) begin
            strobe(1'b0);
            if (busy !== 1'b0 || data_valid !== 1'b0) seen_activity = 1'b1;
        end
        chk("brk_held_low_quiet", 16'(seen_activity), 16'h0);
        strobe(1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        chk("recov_data", 16'(data_out), 16'h003C);
        chk("recov_ferr", 16'(frame_err), 16'h0);
        chk("recov_perr", 16'(parity_err), 16'h0);

        // reset after four data bits of 0xFF, with the strobe still active
        idle_cycle();
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        chk("pre_rst_busy", 16'(busy), 16'h1);
        @(negedge clk);
        rst    = 1'b1;
        bit_en = 1'b1;
        rx_in  = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_data", 16'(data_out), 16'h0);
        chk("mid_rst_valid", 16'(data_valid), 16'h0);
        chk("mid_rst_perr", 16'(parity_err), 16'h0);
        chk("mid_rst_ferr", 16'(frame_err), 16'h0);
        @(negedge clk);
        rst    = 1'b0;
        bit_en = 1'b0;
        idle_cycle();
        chk("post_rst_valid", 16'(data_valid), 16'h0);
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        chk("post_rst_data", 16'(data_out), 16'h003C);
        chk("post_rst_perr", 16'(parity_err), 16'h0);

        // 0x96 with three idle cycles between strobes and rx_in toggling
        idle_cycle();
        send_frame(8'h96, 1'b0, 1'b1, 3);
        chk("gap_data", 16'(data_out), 16'h0096);
        chk("gap_perr", 16'(parity_err), 16'h0);
        chk("gap_ferr", 16'(frame_err), 16'h0);

        // 0x00: odd instance expects parity 1, even instance expects 0
        idle_cycle();
        send_frame(8'h00, 1'b1, 1'b1, 0);
        chk("odd_p1_data", 16'(o_data_out), 16'h0000);
        chk("odd_p1_valid", 16'(o_data_valid), 16'h1);
        chk("odd_p1_perr", 16'(o_parity_err), 16'h0);
        chk("even_p1_perr", 16'(parity_err), 16'h1);
        send_frame(8'h00, 1'b0, 1'b1, 0);
        chk("odd_p0_perr", 16'(o_parity_err), 16'h1);
        chk("odd_p0_ferr", 16'(o_frame_err), 16'h0);
        chk("even_p0_perr", 16'(parity_err), 16'h0);
        idle_cycle();
        chk("odd_valid_drop", 16'(o_data_valid), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
